mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 157 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage handshake with the data memory plus the MEM/WB pipeline register.
// All state moves on the falling edge of Clk, in step with the upstream EX/MEM register.
module mem_wb_stage (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        RegWriteIn,
  input  logic        MoveNotZeroIn,
  input  logic        DontMoveIn,
  input  logic        HiOrLoIn,
  input  logic        MemToRegIn,
  input  logic        HiLoToRegIn,
  input  logic        MemWriteIn,
  input  logic        BranchIn,
  input  logic        MemReadIn,
  input  logic [31:0] RHiIn,
  input  logic [31:0] RLoIn,
  input  logic [31:0] AddResultIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] RD2In,
  input  logic        ZeroIn,
  input  logic [4:0]  WriteAddressIn,
  output logic        DMemReq,
  output logic        DMemRead,
  output logic        DMemWrite,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData,
  output logic        Stall,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        RegWriteOut,
  output logic [4:0]  WriteAddressOut,
  output logic [31:0] WriteDataOut,
  output logic        MemError
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] load_q;
  logic        mem_err_q;
  logic        reg_write_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  logic        access_s;
  logic        stall_s;
  logic        we_s;
  logic [31:0] wb_data_s;
  logic        reg_write_d;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d;

  // Access decode, stall, writeback enable/data and MEM/WB next state
  always_comb begin
    access_s = MemReadIn | MemWriteIn;
    case (state_q)
      IDLE:    stall_s = access_s;
      ACCESS:  stall_s = 1'b1;
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
    we_s = RegWriteIn
         & ~(MoveNotZeroIn & (RD2In == 32'd0))
         & ~(DontMoveIn & (RD2In != 32'd0))
         & ~(MoveNotZeroIn & DontMoveIn);
    if (HiLoToRegIn) begin
      wb_data_s = HiOrLoIn ? RHiIn : RLoIn;
    end else if (MemToRegIn) begin
      wb_data_s = load_q;
    end else begin
      wb_data_s = ALUResultIn;
    end
    // A stalled cycle inserts a bubble but keeps the last address/data visible
    if (stall_s) begin
      reg_write_d = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
    end else begin
      reg_write_d = we_s;
      waddr_d     = WriteAddressIn;
      wdata_d     = wb_data_s;
    end
  end

  // Memory access FSM with ack timeout, load capture and sticky error flag
  always_ff @(negedge Clk) begin
    if (!Rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      load_q    <= 32'd0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access_s) begin
            state_q <= ACCESS;
            cnt_q   <= 4'd0;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          if (DMemAck) begin
            load_q  <= DMemRData;
            state_q <= DONE;
          end else if (cnt_q == 4'd15) begin
            load_q    <= 32'd0;
            mem_err_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // MEM/WB pipeline register
  always_ff @(negedge Clk) begin
    if (!Rst) begin
      reg_write_q <= 1'b0;
      waddr_q     <= 5'd0;
      wdata_q     <= 32'd0;
    end else begin
      reg_write_q <= reg_write_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign DMemReq         = (state_q == ACCESS);
  assign DMemRead        = DMemReq & MemReadIn;
  assign DMemWrite       = DMemReq & MemWriteIn & ~MemReadIn;
  assign DMemAddr        = ALUResultIn;
  assign DMemWData       = RD2In;
  assign Stall           = stall_s;
  assign PCSrc           = BranchIn & ZeroIn & ~stall_s;
  assign BranchTarget    = AddResultIn;
  assign RegWriteOut     = reg_write_q;
  assign WriteAddressOut = waddr_q;
  assign WriteDataOut    = wdata_q;
  assign MemError        = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected writebacks are queued on issue
// and compared when the stage releases the instruction (Stall low at the edge).
module tb_mem_wb_stage;

  logic        Clk;
  logic        Rst;
  logic        RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn, MemToRegIn;
  logic        HiLoToRegIn, MemWriteIn, BranchIn, MemReadIn, ZeroIn;
  logic [31:0] RHiIn, RLoIn, AddResultIn, ALUResultIn, RD2In;
  logic [4:0]  WriteAddressIn;
  logic        DMemReq, DMemRead, DMemWrite, DMemAck;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic        Stall, PCSrc, RegWriteOut, MemError;
  logic [31:0] BranchTarget, WriteDataOut;
  logic [4:0]  WriteAddressOut;

  mem_wb_stage dut (
    .Clk(Clk), .Rst(Rst),
    .RegWriteIn(RegWriteIn), .MoveNotZeroIn(MoveNotZeroIn), .DontMoveIn(DontMoveIn),
    .HiOrLoIn(HiOrLoIn), .MemToRegIn(MemToRegIn), .HiLoToRegIn(HiLoToRegIn),
    .MemWriteIn(MemWriteIn), .BranchIn(BranchIn), .MemReadIn(MemReadIn),
    .RHiIn(RHiIn), .RLoIn(RLoIn), .AddResultIn(AddResultIn), .ALUResultIn(ALUResultIn),
    .RD2In(RD2In), .ZeroIn(ZeroIn), .WriteAddressIn(WriteAddressIn),
    .DMemReq(DMemReq), .DMemRead(DMemRead), .DMemWrite(DMemWrite),
    .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemAck(DMemAck), .DMemRData(DMemRData),
    .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .RegWriteOut(RegWriteOut), .WriteAddressOut(WriteAddressOut),
    .WriteDataOut(WriteDataOut), .MemError(MemError)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rw, movn, movz, hilo, m2r, hl2r, mw, br, mr, zero, ack_idle;
    logic [31:0] rhi, rlo, add, alu, rd2, rdata;
    logic [4:0]  wa;
    int          ack_at;
  } instr_t;

  typedef struct {
    int          stall_cyc, req_cyc;
    logic        pc_first, pc_stall, rd_seen, wr_seen, done;
    logic [31:0] addr_seen, wdata_seen, bt_first;
  } obs_t;

  typedef struct {
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          total_cnt = 0;
  int          bad_cnt   = 0;
  logic [31:0] model_load = 32'd0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic instr_t nop_instr();
    instr_t n;
    n.rw = 1'b0; n.movn = 1'b0; n.movz = 1'b0; n.hilo = 1'b0; n.m2r = 1'b0;
    n.hl2r = 1'b0; n.mw = 1'b0; n.br = 1'b0; n.mr = 1'b0; n.zero = 1'b0;
    n.ack_idle = 1'b0;
    n.rhi = 32'd0; n.rlo = 32'd0; n.add = 32'd0; n.alu = 32'd0; n.rd2 = 32'd0;
    n.rdata = 32'd0; n.wa = 5'd0; n.ack_at = 0;
    return n;
  endfunction

  function automatic logic model_we(input instr_t in);
    if (!in.rw) return 1'b0;
    if (in.movn && in.movz) return 1'b0;
    if (in.movn) return (in.rd2 != 32'd0);
    if (in.movz) return (in.rd2 == 32'd0);
    return 1'b1;
  endfunction

  task automatic drive(input instr_t in);
    RegWriteIn = in.rw; MoveNotZeroIn = in.movn; DontMoveIn = in.movz;
    HiOrLoIn = in.hilo; MemToRegIn = in.m2r; HiLoToRegIn = in.hl2r;
    MemWriteIn = in.mw; BranchIn = in.br; MemReadIn = in.mr; ZeroIn = in.zero;
    RHiIn = in.rhi; RLoIn = in.rlo; AddResultIn = in.add; ALUResultIn = in.alu;
    RD2In = in.rd2; WriteAddressIn = in.wa;
  endtask

  // Present one instruction, serve the memory side, then score its writeback
  task automatic issue(input string tag, input instr_t in, output obs_t ob);
    exp_t        e, g;
    logic [31:0] mem;
    logic        st;
    int          req_n;
    req_n = 0;
    ob.stall_cyc = 0; ob.req_cyc = 0; ob.pc_first = 1'b0; ob.pc_stall = 1'b0;
    ob.rd_seen = 1'b0; ob.wr_seen = 1'b0; ob.done = 1'b0;
    ob.addr_seen = 32'd0; ob.wdata_seen = 32'd0; ob.bt_first = 32'd0;
    drive(in);
    if (in.mr || in.mw) mem = (in.ack_at != 0) ? in.rdata : 32'd0;
    else mem = model_load;
    e.rw = model_we(in);
    e.wa = in.wa;
    if (in.hl2r) e.data = in.hilo ? in.rhi : in.rlo;
    else if (in.m2r) e.data = mem;
    else e.data = in.alu;
    sb_q.push_back(e);
    for (int cyc = 0; cyc < 40 && !ob.done; cyc++) begin
      @(posedge Clk);
      st = Stall;
      if (cyc == 0) begin
        ob.pc_first = PCSrc;
        ob.bt_first = BranchTarget;
      end
      if (st) begin
        ob.stall_cyc++;
        ob.pc_stall = ob.pc_stall | PCSrc;
      end
      if (DMemReq) begin
        req_n++;
        ob.req_cyc++;
        if (req_n == 1) begin
          ob.addr_seen  = DMemAddr;
          ob.wdata_seen = DMemWData;
        end
        ob.rd_seen = ob.rd_seen | DMemRead;
        ob.wr_seen = ob.wr_seen | DMemWrite;
        if (req_n == in.ack_at) begin
          DMemAck = 1'b1; DMemRData = in.rdata;
        end else begin
          DMemAck = 1'b0; DMemRData = 32'hBAD0_0000 + 32'(req_n);
        end
      end else begin
        DMemAck = in.ack_idle; DMemRData = 32'hCAFE_F00D;
      end
      @(negedge Clk);
      #1;
      DMemAck = 1'b0;
      if (!st) ob.done = 1'b1;
    end
    if (!ob.done) begin
      check_value({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (sb_q.size() == 0) begin
      check_value({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      check_value({tag, "_rw"}, 32'(RegWriteOut), 32'(g.rw));
      check_value({tag, "_wa"}, 32'(WriteAddressOut), 32'(g.wa));
      check_value({tag, "_wd"}, WriteDataOut, g.data);
    end
    if (in.mr || in.mw) model_load = mem;
    drive(nop_instr());
  endtask

  initial begin
    instr_t i;
    obs_t   o;
    logic   found;
    Rst = 1'b0; DMemAck = 1'b0; DMemRData = 32'd0;
    drive(nop_instr());
    repeat (2) @(negedge Clk);
    #1;
    check_value("rst_rw", 32'(RegWriteOut), 32'd0);
    check_value("rst_wa", 32'(WriteAddressOut), 32'd0);
    check_value("rst_wd", WriteDataOut, 32'd0);
    check_value("rst_err", 32'(MemError), 32'd0);
    check_value("rst_req", 32'(DMemReq), 32'd0);
    Rst = 1'b1;

    i = nop_instr(); i.rw = 1'b1; i.alu = 32'h1234; i.wa = 5'd5;
    issue("alu", i, o);
    check_value("alu_stall", 32'(o.stall_cyc), 32'd0);

    i = nop_instr(); i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; i.wa = 5'd7;
    i.alu = 32'h100; i.ack_at = 2; i.rdata = 32'hDEAD_BEEF;
    issue("load", i, o);
    check_value("load_stall", 32'(o.stall_cyc), 32'd3);
    check_value("load_req", 32'(o.req_cyc), 32'd2);
    check_value("load_addr", o.addr_seen, 32'h100);
    check_value("load_rd", 32'(o.rd_seen), 32'd1);
    check_value("load_wr", 32'(o.wr_seen), 32'd0);
    check_value("load_err", 32'(MemError), 32'd0);

    i = nop_instr(); i.rw = 1'b1; i.movn = 1'b1; i.rd2 = 32'd0; i.alu = 32'h55; i.wa = 5'd8;
    issue("movn_z", i, o);
    i = nop_instr(); i.rw = 1'b1; i.movz = 1'b1; i.rd2 = 32'd0; i.alu = 32'h66; i.wa = 5'd9;
    issue("movz_z", i, o);
    i = nop_instr(); i.rw = 1'b1; i.movn = 1'b1; i.movz = 1'b1; i.rd2 = 32'd4; i.wa = 5'd10;
    issue("movnz", i, o);
    i = nop_instr(); i.rw = 1'b1; i.hl2r = 1'b1; i.hilo = 1'b1; i.rhi = 32'h7; i.rlo = 32'h9; i.wa = 5'd11;
    issue("hi", i, o);
    i = nop_instr(); i.rw = 1'b1; i.hl2r = 1'b1; i.m2r = 1'b1; i.rhi = 32'h7; i.rlo = 32'h9; i.wa = 5'd12;
    issue("lo_prio", i, o);

    i = nop_instr(); i.br = 1'b1; i.zero = 1'b1; i.add = 32'h40;
    issue("br", i, o);
    check_value("br_pcsrc", 32'(o.pc_first), 32'd1);
    check_value("br_target", o.bt_first, 32'h40);
    i = nop_instr(); i.br = 1'b1; i.zero = 1'b1; i.add = 32'h40; i.mr = 1'b1;
    i.ack_at = 1; i.rdata = 32'h11;
    issue("br_acc", i, o);
    check_value("br_acc_pc_first", 32'(o.pc_first), 32'd0);
    check_value("br_acc_pc_stall", 32'(o.pc_stall), 32'd0);
    check_value("br_acc_stall", 32'(o.stall_cyc), 32'd2);

    i = nop_instr(); i.mw = 1'b1; i.rd2 = 32'h55; i.alu = 32'h200; i.wa = 5'd13;
    issue("store_to", i, o);
    check_value("store_req", 32'(o.req_cyc), 32'd16);
    check_value("store_stall", 32'(o.stall_cyc), 32'd17);
    check_value("store_wdata", o.wdata_seen, 32'h55);
    check_value("store_wr", 32'(o.wr_seen), 32'd1);
    check_value("store_rd", 32'(o.rd_seen), 32'd0);
    check_value("store_err", 32'(MemError), 32'd1);
    i = nop_instr(); i.rw = 1'b1; i.alu = 32'hA5A5; i.wa = 5'd14;
    issue("alu2", i, o);
    check_value("err_sticky", 32'(MemError), 32'd1);

    // Reset in the middle of a load, then a late ack that must be ignored
    i = nop_instr(); i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; i.wa = 5'd9; i.alu = 32'h300;
    drive(i);
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      @(posedge Clk);
      if (DMemReq === 1'b1) found = 1'b1;
      else begin
        @(negedge Clk);
        #1;
      end
    end
    check_value("abort_req_seen", 32'(found), 32'd1);
    Rst = 1'b0;
    @(negedge Clk);
    #1;
    check_value("abort_req", 32'(DMemReq), 32'd0);
    check_value("abort_rw", 32'(RegWriteOut), 32'd0);
    check_value("abort_wa", 32'(WriteAddressOut), 32'd0);
    check_value("abort_wd", WriteDataOut, 32'd0);
    check_value("abort_err", 32'(MemError), 32'd0);
    drive(nop_instr());
    Rst = 1'b1; DMemAck = 1'b1; DMemRData = 32'hCAFE_F00D;
    #1;
    check_value("abort_stall", 32'(Stall), 32'd0);
    @(negedge Clk);
    #1;
    DMemAck = 1'b0;
    check_value("abort_nowb", 32'(RegWriteOut), 32'd0);
    model_load = 32'd0;
    i = nop_instr(); i.rw = 1'b1; i.m2r = 1'b1; i.wa = 5'd3; i.ack_idle = 1'b1;
    issue("ack_ignored", i, o);
    check_value("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
